// File: rtl/trace_capture_reader.sv
// Circular trace buffer: captures one sample per clock while armed, freezes on
// trigger plus post-count, then streams the window oldest-first as OUT_W words.
module trace_capture_reader #(
  parameter int DATA_W  = 256,
  parameter int DEPTH_W = 10,
  parameter int OUT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               abort,
  input  logic [DEPTH_W-1:0] post_cnt,
  input  logic               trig_in,
  input  logic [DATA_W-1:0]  data,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [OUT_W-1:0]   rd_data,
  output logic               rd_last,
  output logic [1:0]         state,
  output logic [DEPTH_W-1:0] trig_pos
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam int WPS   = DATA_W / OUT_W;
  localparam int WC_W  = (WPS > 1) ? $clog2(WPS) : 1;
  localparam logic [WC_W-1:0]  W_LAST = WC_W'(WPS - 1);
  localparam logic [DEPTH_W:0] N_FULL = (DEPTH_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_READ  = 2'd3
  } state_t;

  state_t             st;
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W:0]   n;
  logic [DEPTH_W-1:0] pc;
  logic [DEPTH_W-1:0] remaining;
  logic [DEPTH_W-1:0] iss_addr;
  logic [DEPTH_W:0]   iss_left;
  logic               q_vld, q_last;
  logic [DATA_W-1:0]  ram_q;
  logic [DATA_W-1:0]  pf;
  logic               pf_valid, pf_last;
  logic [DATA_W-1:0]  cur;
  logic               cur_valid, cur_last;
  logic [WC_W-1:0]    widx;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               wr_en, go_read, xfer, cur_done, cur_free, issue;
  logic [DEPTH_W:0]   n_inc;
  logic [1:0]         occ;

  assign wr_en    = (st == S_ARMED || st == S_POST) && !abort;
  assign n_inc    = (n == N_FULL) ? n : n + 1'b1;
  assign go_read  = (st == S_ARMED && trig_in && pc == '0) ||
                    (st == S_POST && remaining == DEPTH_W'(1));
  assign xfer     = cur_valid && rd_ready;
  assign cur_done = xfer && (widx == W_LAST);
  assign cur_free = !cur_valid || cur_done;
  // Samples held or in flight after this cycle's consumption; two slots (cur, pf)
  // are enough to absorb a read that lands while the host stalls.
  assign occ      = 2'(cur_valid) + 2'(pf_valid) + 2'(q_vld) - 2'(cur_done);
  assign issue    = (st == S_READ) && (iss_left != '0) && (occ < 2'd2);

  // rd_valid/rd_ready: a word moves when both are high; while stalled rd_data and
  // rd_last hold, and rd_valid only drops after the final transfer, abort or rst.
  assign rd_valid = cur_valid;
  assign rd_data  = cur[OUT_W-1:0];
  assign rd_last  = cur_valid && cur_last && (widx == W_LAST);
  assign state    = st;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data;
    ram_q <= mem[iss_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      wr_ptr    <= '0;
      n         <= '0;
      pc        <= '0;
      remaining <= '0;
      iss_addr  <= '0;
      iss_left  <= '0;
      q_vld     <= 1'b0;
      q_last    <= 1'b0;
      pf        <= '0;
      pf_valid  <= 1'b0;
      pf_last   <= 1'b0;
      cur       <= '0;
      cur_valid <= 1'b0;
      cur_last  <= 1'b0;
      widx      <= '0;
      trig_pos  <= '0;
    end else if (abort) begin
      st        <= S_IDLE;
      iss_left  <= '0;
      q_vld     <= 1'b0;
      pf_valid  <= 1'b0;
      cur_valid <= 1'b0;
      widx      <= '0;
      trig_pos  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        n      <= n_inc;
      end

      case (st)
        S_IDLE: if (arm) begin
          st     <= S_ARMED;
          // The port width already bounds post_cnt to DEPTH-1.
          pc     <= post_cnt;
          n      <= '0;
          wr_ptr <= '0;
        end
        S_ARMED: if (trig_in && pc != '0) begin
          st        <= S_POST;
          remaining <= pc;
        end
        S_POST: remaining <= remaining - 1'b1;
        S_READ: if (cur_done && cur_last) begin
          st       <= S_IDLE;
          trig_pos <= '0;
        end
        default: st <= S_IDLE;
      endcase

      // Window is the last n_inc samples, ending with this cycle's write.
      if (go_read) begin
        st       <= S_READ;
        iss_addr <= wr_ptr + 1'b1 - n_inc[DEPTH_W-1:0];
        iss_left <= n_inc;
        trig_pos <= n_inc[DEPTH_W-1:0] - 1'b1 - pc;
      end

      q_vld <= issue;
      if (issue) begin
        q_last   <= (iss_left == (DEPTH_W + 1)'(1));
        iss_addr <= iss_addr + 1'b1;
        iss_left <= iss_left - 1'b1;
      end

      if (xfer && !cur_done) begin
        cur  <= cur >> OUT_W;
        widx <= widx + 1'b1;
      end

      if (cur_free) begin
        widx <= '0;
        if (pf_valid) begin
          cur       <= pf;
          cur_last  <= pf_last;
          cur_valid <= 1'b1;
        end else if (q_vld) begin
          cur       <= ram_q;
          cur_last  <= q_last;
          cur_valid <= 1'b1;
        end else begin
          cur_valid <= 1'b0;
        end
      end

      if (q_vld && (!cur_free || pf_valid)) begin
        pf       <= ram_q;
        pf_last  <= q_last;
        pf_valid <= 1'b1;
      end else if (cur_free && pf_valid) begin
        pf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trace_capture_reader.sv
// Bench for trace_capture_reader: table of capture scenarios checked through a
// word scoreboard, plus hand sequences for abort, rst in POST and ignored inputs.
module tb_trace_capture_reader;

  localparam int DATA_W  = 64;
  localparam int DEPTH_W = 4;
  localparam int OUT_W   = 32;
  localparam int W       = OUT_W + 1;

  logic               clk, rst, arm, abort, trig_in, rd_ready;
  logic [DEPTH_W-1:0] post_cnt;
  logic [DATA_W-1:0]  data;
  logic               rd_valid, rd_last;
  logic [OUT_W-1:0]   rd_data;
  logic [1:0]         state;
  logic [DEPTH_W-1:0] trig_pos;

  typedef struct {
    logic [DEPTH_W-1:0] pc;
    int                 trig_k;
    bit                 stall;
    bit                 hi100;
    bit                 noise;
    int                 exp_n;
    int                 exp_first;
    int                 exp_tp;
  } vec_t;

  vec_t       vecs[6];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] prev_word;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         xfer_cnt = 0;
  bit         prev_stall = 0;
  bit         post_last = 0;

  trace_capture_reader #(.DATA_W(DATA_W), .DEPTH_W(DEPTH_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .post_cnt(post_cnt),
    .trig_in(trig_in), .data(data), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_last(rd_last), .state(state), .trig_pos(trig_pos)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] sample(input int k, input bit hi100);
    logic [31:0] lo, hi;
    lo = 32'(k);
    hi = hi100 ? 32'(k + 100) : 32'(k);
    return {hi, lo};
  endfunction

  function automatic logic ready_pat(input bit stall, input int c);
    return stall ? ((c % 3) == 0) : 1'b1;
  endfunction

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      post_last  = 0;
    end else begin
      if (post_last) begin
        check("idle_after_last", 64'(state), 64'd0);
        check("valid_after_last", 64'(rd_valid), 64'd0);
        post_last = 0;
      end
      if (prev_stall) begin
        check("stall_hold_valid", 64'(rd_valid), 64'd1);
        check("stall_hold_word", 64'({rd_last, rd_data}), 64'(prev_word));
      end
      if (rd_valid && rd_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got 0x%0h, expected none", {rd_last, rd_data});
        end else begin
          mon_exp = exp_q.pop_front();
          check("word", 64'({rd_last, rd_data}), 64'(mon_exp));
        end
        if (rd_last) post_last = 1;
      end
      prev_stall = rd_valid && !rd_ready && !abort;
      prev_word  = {rd_last, rd_data};
    end
  end

  // driver tasks
  task automatic arm_dut(input logic [DEPTH_W-1:0] pc);
    @(posedge clk); #1;
    arm = 1'b1;
    post_cnt = pc;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic run_capture(input vec_t v);
    int last_k;
    int c;
    last_k = v.trig_k + int'(v.pc);
    for (int i = 0; i < v.exp_n; i++) begin
      logic [DATA_W-1:0] s;
      s = sample(v.exp_first + i, v.hi100);
      exp_q.push_back({1'b0, s[31:0]});
      exp_q.push_back({(i == v.exp_n - 1), s[63:32]});
    end
    arm_dut(v.pc);
    check("state_armed", 64'(state), 64'd1);
    for (int k = 0; k <= last_k; k++) begin
      data = sample(k, v.hi100);
      trig_in = (k == v.trig_k) || (v.noise && k > v.trig_k);
      @(posedge clk); #1;
    end
    trig_in = 1'b0;
    c = 0;
    check("read_entry", 64'(state), 64'd3);
    check("trig_pos", 64'(trig_pos), 64'(v.exp_tp));
    check("lat_e0", 64'(rd_valid), 64'd0);
    rd_ready = ready_pat(v.stall, c);
    @(posedge clk); #1;
    c = 1;
    check("lat_e1", 64'(rd_valid), 64'd0);
    rd_ready = ready_pat(v.stall, c);
    @(posedge clk); #1;
    c = 2;
    check("lat_e2", 64'(rd_valid), 64'd1);
    rd_ready = ready_pat(v.stall, c);
    if (v.noise) begin
      arm = 1'b1;
      trig_in = 1'b1;
    end
    while (state != 2'd0 && c < 400) begin
      @(posedge clk); #1;
      c++;
      arm = 1'b0;
      trig_in = 1'b0;
      rd_ready = ready_pat(v.stall, c);
      if (v.noise && c == 3) check("arm_in_read", 64'(state), 64'd3);
    end
    check("read_timeout", 64'(c < 400), 64'd1);
    if (!v.stall) check("throughput_cycles", 64'(c), 64'(2 + 2 * v.exp_n));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic abort_sequence();
    int i;
    arm_dut(DEPTH_W'(3));
    for (int k = 0; k <= 7; k++) begin
      data = sample(k, 1'b0);
      trig_in = (k == 4);
      @(posedge clk); #1;
    end
    trig_in = 1'b0;
    exp_q.push_back({1'b0, 32'd0});
    exp_q.push_back({1'b0, 32'd0});
    exp_q.push_back({1'b0, 32'd1});
    exp_q.push_back({1'b0, 32'd1});
    exp_q.push_back({1'b0, 32'd2});
    xfer_cnt = 0;
    rd_ready = 1'b1;
    i = 0;
    while (xfer_cnt < 5 && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    abort = 1'b1;
    rd_ready = 1'b0;
    check("abort_xfers", 64'(xfer_cnt), 64'd5);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", 64'(rd_valid), 64'd0);
    check("abort_last", 64'(rd_last), 64'd0);
    check("abort_state", 64'(state), 64'd0);
    check("abort_queue", 64'(exp_q.size()), 64'd0);
    rd_ready = 1'b1;
  endtask

  task automatic rst_in_post();
    arm_dut(DEPTH_W'(10));
    for (int k = 0; k <= 4; k++) begin
      data = sample(k, 1'b0);
      trig_in = (k == 2);
      @(posedge clk); #1;
    end
    trig_in = 1'b0;
    check("post_state", 64'(state), 64'd2);
    rst = 1'b1;
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_last", 64'(rd_last), 64'd0);
    check("rst_data", 64'(rd_data), 64'd0);
    check("rst_trig_pos", 64'(trig_pos), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{DEPTH_W'(3),  20, 1'b0, 1'b0, 1'b0, 16, 8,  12};
    vecs[1] = '{DEPTH_W'(3),  2,  1'b0, 1'b0, 1'b1, 6,  0,  2};
    vecs[2] = '{DEPTH_W'(3),  20, 1'b1, 1'b1, 1'b0, 16, 8,  12};
    vecs[3] = '{DEPTH_W'(15), 30, 1'b0, 1'b0, 1'b0, 16, 30, 0};
    vecs[4] = '{DEPTH_W'(0),  17, 1'b0, 1'b0, 1'b0, 16, 2,  15};
    vecs[5] = '{DEPTH_W'(0),  0,  1'b0, 1'b0, 1'b0, 1,  0,  0};

    rst = 1'b1;
    arm = 1'b0;
    abort = 1'b0;
    trig_in = 1'b0;
    rd_ready = 1'b1;
    post_cnt = '0;
    data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'(state), 64'd0);
    check("reset_valid", 64'(rd_valid), 64'd0);
    check("reset_last", 64'(rd_last), 64'd0);
    check("reset_data", 64'(rd_data), 64'd0);
    check("reset_trig_pos", 64'(trig_pos), 64'd0);
    rst = 1'b0;

    trig_in = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("trig_in_idle", 64'(state), 64'd0);
    end
    trig_in = 1'b0;
    arm = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    abort = 1'b0;
    check("arm_abort_idle", 64'(state), 64'd0);

    for (int t = 0; t < 5; t++) run_capture(vecs[t]);

    abort_sequence();
    run_capture(vecs[5]);

    rst_in_post();
    run_capture(vecs[0]);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
